burst_ctrl: RTL

Burst sequencer for the SPS burst path: accepts a burst request (base address, length, direction), drives the MRAM-side beat strobes and address, and counts accepted beats. It sits directly upstream of the `compare` stage. It feeds `compare` its latched `burst_len` and `counter`, and consumes the returned `stop_signal` to end the burst.

---
 rtl/burst_ctrl.sv | 82 ++++++++
 1 files changed

// File: rtl/burst_ctrl.sv
// Burst sequencer: latches a burst request, issues one beat per mem_ready
// handshake and hands burst_len/counter to the downstream compare stage.
module burst_ctrl #(
    parameter int ADDR_WIDTH    = 8,
    parameter int COUNTER_WIDTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic                     rw,
    input  logic [ADDR_WIDTH-1:0]    base_addr,
    input  logic [COUNTER_WIDTH-1:0] burst_len_in,
    input  logic                     abort,
    input  logic                     mem_ready,
    input  logic                     stop_signal,
    output logic [COUNTER_WIDTH-1:0] burst_len,
    output logic [COUNTER_WIDTH-1:0] counter,
    output logic [ADDR_WIDTH-1:0]    addr,
    output logic                     mem_en,
    output logic                     mem_we,
    output logic                     busy,
    output logic                     done
);

    typedef enum logic [1:0] {IDLE, ISSUE, DONE} state_t;

    // Largest length whose beat count (len+1) is still representable in counter.
    localparam logic [COUNTER_WIDTH-1:0] LEN_MAX = {{(COUNTER_WIDTH-1){1'b1}}, 1'b0};

    state_t state, state_nxt;

    function automatic logic [COUNTER_WIDTH-1:0] clamp_len(input logic [COUNTER_WIDTH-1:0] len);
        return (len > LEN_MAX) ? LEN_MAX : len;
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        mem_en    = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: begin
                if (start) state_nxt = ISSUE;
            end
            ISSUE: begin
                busy   = 1'b1;
                mem_en = ~stop_signal;
                if (stop_signal || abort) state_nxt = DONE;
            end
            DONE: begin
                busy      = 1'b1;
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // A beat accepted alongside abort still advances counter and addr.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            burst_len <= '0;
            counter   <= '0;
            addr      <= '0;
            mem_we    <= 1'b0;
        end else if (state == IDLE && start) begin
            burst_len <= clamp_len(burst_len_in);
            counter   <= '0;
            addr      <= base_addr;
            mem_we    <= rw;
        end else if (mem_en && mem_ready) begin
            counter <= counter + 1'b1;
            addr    <= addr + 1'b1;
        end
    end

endmodule
